// File: rtl/result_packer_pkg.sv
// ---------------------------------------------------------------------------
// result_packer_pkg
//   Shared definitions for the result packer slice.
//   - pk_state_t : packer FSM state encodings (PK_EMPTY, PK_HALF, PK_FLUSH)
//   - PK_PAD_DEFAULT : default filler for the empty half of an odd flush word
//   - RESULT_W : width of one engine result, independent of burst length
// ---------------------------------------------------------------------------
package result_packer_pkg;

  localparam int          RESULT_W       = 16;
  localparam logic [15:0] PK_PAD_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    PK_EMPTY = 2'd0,  // no half-word held
    PK_HALF  = 2'd1,  // first result of a pair held in low_reg
    PK_FLUSH = 2'd2   // flush requested, waiting for the skid to drain
  } pk_state_t;

endpackage

// File: rtl/result_skid_fifo.sv
// ---------------------------------------------------------------------------
// result_skid_fifo
//   Small first-word-fall-through FIFO holding packed result words while the
//   downstream result FIFO is full. Storage is a register array written on
//   push; the head entry is read combinationally from that registered storage.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (pointers only)
//   push       : write push_data (ignored when full unless pop is also high)
//   push_data  : word to store
//   pop        : remove the head entry (ignored when empty)
//   head_data  : current head entry
//   full/empty : occupancy flags
//
// DEPTH must be a power of two and at least 2.
// ---------------------------------------------------------------------------
module result_skid_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  // A push while full is legal when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Storage carries no reset so it can map onto distributed/block memory.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  assign head_data = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/result_packer.sv
// ---------------------------------------------------------------------------
// result_packer
//   Packs pairs of 16-bit engine results into 32-bit result FIFO words.
//   The engine cannot be stalled, so short FIFO-full periods are absorbed by
//   a small skid FIFO; anything beyond that is dropped and flagged. A flush
//   pads an odd trailing result, drains the skid and pulses flush_done.
//
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   in_valid    : engine result strobe
//   in_data     : engine result
//   flush       : one-cycle pulse, no more results for this layer
//   fifo_full   : result FIFO full flag
//   out_wr_en   : result FIFO write enable (combinational)
//   out_data    : packed word (skid head)
//   busy        : half-word held, skid non-empty or flush in progress
//   flush_done  : one-cycle pulse once a flush has fully drained
//   overflow    : sticky, a result or packed word was dropped
//   in_count    : results accepted since reset (wraps)
//   out_count   : words written to the FIFO since reset (wraps)
//
// Build option: define RESULT_PACKER_HI_FIRST_EN to place the first result
// of a pair in the upper half (odd flush then gives {first, PAD_VALUE}).
// ---------------------------------------------------------------------------
module result_packer
  import result_packer_pkg::*;
#(
  parameter int                DATA_W     = RESULT_W,
  parameter int                SKID_DEPTH = 4,
  parameter int                CNT_W      = 16,
  parameter logic [DATA_W-1:0] PAD_VALUE  = PK_PAD_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                flush,
  input  logic                fifo_full,
  output logic                out_wr_en,
  output logic [2*DATA_W-1:0] out_data,
  output logic                busy,
  output logic                flush_done,
  output logic                overflow,
  output logic [CNT_W-1:0]    in_count,
  output logic [CNT_W-1:0]    out_count
);

  pk_state_t           state_reg, state_next;
  logic [DATA_W-1:0]   low_reg, low_next;
  logic                overflow_reg;
  logic [CNT_W-1:0]    in_count_reg;
  logic [CNT_W-1:0]    out_count_reg;

  logic                push;
  logic [2*DATA_W-1:0] push_word;
  logic                accept;
  logic                in_drop;
  logic                skid_full;
  logic                skid_empty;
  logic                skid_drop;

`ifdef RESULT_PACKER_HI_FIRST_EN
  function automatic logic [2*DATA_W-1:0] pack_pair(input logic [DATA_W-1:0] first,
                                                    input logic [DATA_W-1:0] second);
    return {first, second};
  endfunction
  function automatic logic [2*DATA_W-1:0] pack_pad(input logic [DATA_W-1:0] first);
    return {first, PAD_VALUE};
  endfunction
`else
  function automatic logic [2*DATA_W-1:0] pack_pair(input logic [DATA_W-1:0] first,
                                                    input logic [DATA_W-1:0] second);
    return {second, first};
  endfunction
  function automatic logic [2*DATA_W-1:0] pack_pad(input logic [DATA_W-1:0] first);
    return {PAD_VALUE, first};
  endfunction
`endif

  // The sample of a cycle is handled first; a coincident flush then acts on
  // the state that sample produced.
  always_comb begin
    state_next = state_reg;
    low_next   = low_reg;
    push       = 1'b0;
    push_word  = '0;
    accept     = 1'b0;
    in_drop    = 1'b0;
    flush_done = 1'b0;
    unique case (state_reg)
      PK_EMPTY: begin
        if (in_valid) begin
          accept     = 1'b1;
          low_next   = in_data;
          state_next = PK_HALF;
        end
        if (flush) begin
          // A sample just latched is now an odd trailing result.
          if (in_valid) begin
            push      = 1'b1;
            push_word = pack_pad(in_data);
          end
          state_next = PK_FLUSH;
        end
      end
      PK_HALF: begin
        if (in_valid) begin
          accept     = 1'b1;
          push       = 1'b1;
          push_word  = pack_pair(low_reg, in_data);
          state_next = PK_EMPTY;
        end
        if (flush) begin
          if (!in_valid) begin
            push      = 1'b1;
            push_word = pack_pad(low_reg);
          end
          state_next = PK_FLUSH;
        end
      end
      PK_FLUSH: begin
        in_drop = in_valid;
        if (skid_empty) begin
          flush_done = 1'b1;
          state_next = PK_EMPTY;
        end
      end
      default: state_next = PK_EMPTY;
    endcase
  end

  assign out_wr_en = !skid_empty && !fifo_full;
  assign skid_drop = push && skid_full && !out_wr_en;

  result_skid_fifo #(
    .WIDTH (2*DATA_W),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_word),
    .pop       (out_wr_en),
    .head_data (out_data),
    .full      (skid_full),
    .empty     (skid_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= PK_EMPTY;
      low_reg       <= '0;
      overflow_reg  <= 1'b0;
      in_count_reg  <= '0;
      out_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      low_reg   <= low_next;
      if (in_drop || skid_drop) overflow_reg  <= 1'b1;
      if (accept)               in_count_reg  <= in_count_reg + 1'b1;
      if (out_wr_en)            out_count_reg <= out_count_reg + 1'b1;
    end
  end

  assign busy      = (state_reg != PK_EMPTY) || !skid_empty;
  assign overflow  = overflow_reg;
  assign in_count  = in_count_reg;
  assign out_count = out_count_reg;

endmodule
